// File: rtl/deadlock_pkg.sv
// Shared definitions for the per-process deadlock detector and the report unit.
package deadlock_pkg;

    // Widest process vector the helper functions handle; callers cast their
    // PROC_NUM-wide vectors into this width and slice the result back out.
    localparam int DL_VEC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DETECTED = 2'd1,
        ST_ARMED    = 2'd2
    } dl_state_e;

    // Isolate the lowest set bit; all-zero input gives all-zero output.
    function automatic logic [DL_VEC_W-1:0] lowest_onehot(input logic [DL_VEC_W-1:0] vec);
        return vec & (-vec);
    endfunction

    // All ones except the bit belonging to process id.
    function automatic logic [DL_VEC_W-1:0] proc_mask(input int id);
        return ~(DL_VEC_W'(1) << id);
    endfunction

endpackage

// File: rtl/dl_block_timer.sv
// Saturating count of consecutive blocked cycles; hit flags the cycle that
// completes the threshold run.
module dl_block_timer #(
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = $clog2(THRESHOLD + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             blocked,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

    // Count only while enabled and blocked; any gap restarts the run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || !blocked) begin
            count <= '0;
        end else if (count != CNT_SAT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit = enable && blocked && (count == CNT_LAST);

endmodule

// File: rtl/deadlock_detect_unit.sv
// Per-process deadlock detector and token-ring node.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_IDLE     | watching dep_vld, counting consecutive blocked cycles
//   ST_DETECTED | self-deadlock suspected, dl_detect_out held high
//   ST_ARMED    | global deadlock confirmed, dep_reg frozen, forwarding tokens
module deadlock_detect_unit
    import deadlock_pkg::*;
#(
    parameter int PROC_NUM        = 4,
    parameter int PROC_ID         = 0,
    parameter int BLOCK_THRESHOLD = 16,
    parameter int CNT_W           = $clog2(BLOCK_THRESHOLD + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dep_vld,
    input  logic [PROC_NUM-1:0] token_in_vec,
    input  logic                dl_detect_in,
    input  logic                origin,
    input  logic                token_clear,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] token_out_vec
);

    dl_state_e           state;
    logic [PROC_NUM-1:0] dep_reg;
    logic                origin_flag;

    logic [DL_VEC_W-1:0] mask_w;
    logic [DL_VEC_W-1:0] tgt_w;
    logic [PROC_NUM-1:0] own_mask;
    logic [PROC_NUM-1:0] dep_m;
    logic [PROC_NUM-1:0] tok_m;
    logic [PROC_NUM-1:0] tgt;
    logic                blocked;
    logic                tok_hit;
    logic [CNT_W-1:0]    cnt;
    logic                timer_hit;
    logic                unused_bits;

    // Own bit is never a valid dependence or token source.
    assign mask_w   = proc_mask(PROC_ID);
    assign own_mask = mask_w[PROC_NUM-1:0];
    assign dep_m    = dep_vld & own_mask;
    assign tok_m    = token_in_vec & own_mask;
    assign blocked  = |dep_m;
    assign tok_hit  = |tok_m;

    // Token always goes to the lowest recorded dependence.
    assign tgt_w = lowest_onehot(DL_VEC_W'(dep_reg));
    assign tgt   = tgt_w[PROC_NUM-1:0];

    assign unused_bits = ^{mask_w, tgt_w, cnt};

    dl_block_timer #(
        .THRESHOLD (BLOCK_THRESHOLD),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (state == ST_IDLE),
        .blocked (blocked),
        .count   (cnt),
        .hit     (timer_hit)
    );

    // Detection / token-forwarding FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            dep_reg       <= '0;
            origin_flag   <= 1'b0;
            dl_detect_out <= 1'b0;
            token_out_vec <= '0;
        end else begin
            token_out_vec <= '0;
            case (state)
                ST_IDLE: begin
                    dl_detect_out <= 1'b0;
                    if (dl_detect_in) begin
                        // Member of a cycle that never reached the threshold.
                        state   <= ST_ARMED;
                        dep_reg <= dep_m;
                    end else if (timer_hit) begin
                        state         <= ST_DETECTED;
                        dep_reg       <= dep_m;
                        dl_detect_out <= 1'b1;
                    end
                end
                ST_DETECTED: begin
                    if (dl_detect_in) begin
                        // Drop the level as the report unit starts its trace.
                        state         <= ST_ARMED;
                        dl_detect_out <= 1'b0;
                    end else if (!blocked) begin
                        state         <= ST_IDLE;
                        dep_reg       <= '0;
                        dl_detect_out <= 1'b0;
                    end else begin
                        dl_detect_out <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!dl_detect_in) begin
                        state         <= ST_IDLE;
                        dep_reg       <= '0;
                        origin_flag   <= 1'b0;
                        dl_detect_out <= 1'b0;
                    end else begin
                        dl_detect_out <= tok_hit;
                        if (token_clear) begin
                            // End of trace: a coincident origin is ignored.
                            origin_flag <= 1'b0;
                            if (tok_hit && !origin_flag) begin
                                token_out_vec <= tgt;
                            end
                        end else if (origin) begin
                            origin_flag   <= 1'b1;
                            token_out_vec <= tgt;
                        end else if (tok_hit && !origin_flag) begin
                            token_out_vec <= tgt;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    dep_reg       <= '0;
                    origin_flag   <= 1'b0;
                    dl_detect_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deadlock_detect_unit.sv
// Directed bench for deadlock_detect_unit (PROC_NUM=4, PROC_ID=1, threshold 8).
module tb_deadlock_detect_unit;

    localparam int PROC_NUM = 4;
    localparam int PROC_ID  = 1;
    localparam int THRESH   = 8;

    logic                clock;
    logic                reset;
    logic [PROC_NUM-1:0] dep_vld;
    logic [PROC_NUM-1:0] token_in_vec;
    logic                dl_detect_in;
    logic                origin;
    logic                token_clear;
    logic                dl_detect_out;
    logic [PROC_NUM-1:0] token_out_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    deadlock_detect_unit #(
        .PROC_NUM        (PROC_NUM),
        .PROC_ID         (PROC_ID),
        .BLOCK_THRESHOLD (THRESH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .dep_vld       (dep_vld),
        .token_in_vec  (token_in_vec),
        .dl_detect_in  (dl_detect_in),
        .origin        (origin),
        .token_clear   (token_clear),
        .dl_detect_out (dl_detect_out),
        .token_out_vec (token_out_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic exp_dl, input logic [PROC_NUM-1:0] exp_tok);
        n_cmp++;
        assert (dl_detect_out === exp_dl) else begin
            n_fail++;
            $error("FAIL %s dl_detect_out: observed %b expected %b", tag, dl_detect_out, exp_dl);
        end
        n_cmp++;
        assert (token_out_vec === exp_tok) else begin
            n_fail++;
            $error("FAIL %s token_out_vec: observed %b expected %b", tag, token_out_vec, exp_tok);
        end
    endtask

    // Token output must be at most one-hot and never target this process.
    always @(negedge clock) begin
        if (!reset) begin
            n_cmp++;
            assert ($onehot0(token_out_vec) && !token_out_vec[PROC_ID]) else begin
                n_fail++;
                $error("FAIL invariant token_out_vec: observed %b expected onehot0 without bit %0d",
                       token_out_vec, PROC_ID);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        dep_vld      = '0;
        token_in_vec = '0;
        dl_detect_in = 1'b0;
        origin       = 1'b0;
        token_clear  = 1'b0;
        #3;
        chk("reset", 1'b0, 4'b0000);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Detection after 8 blocked cycles; own bit masked out of dep_reg.
        dep_vld = 4'b0110;
        for (int i = 0; i < THRESH - 1; i++) begin
            step();
            chk("t1_count", 1'b0, 4'b0000);
        end
        step(); chk("t1_detect", 1'b1, 4'b0000);
        step(); chk("t1_hold", 1'b1, 4'b0000);
        dl_detect_in = 1'b1;
        step(); chk("t1_armed", 1'b0, 4'b0000);
        dep_vld = 4'b0000; origin = 1'b1;
        step(); chk("t1_origin", 1'b0, 4'b0100);
        origin = 1'b0;
        step(); chk("t1_origin_end", 1'b0, 4'b0000);
        dl_detect_in = 1'b0;
        step(); chk("t1_exit", 1'b0, 4'b0000);

        // False alarms: short run, then detection withdrawn.
        dep_vld = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_short", 1'b0, 4'b0000);
        end
        dep_vld = 4'b0000;
        step(); chk("t2_gap", 1'b0, 4'b0000);
        dep_vld = 4'b1000;
        for (int i = 0; i < THRESH - 1; i++) begin
            step();
            chk("t2_restart", 1'b0, 4'b0000);
        end
        step(); chk("t2_detect", 1'b1, 4'b0000);
        dep_vld = 4'b0000;
        step(); chk("t2_false_alarm", 1'b0, 4'b0000);
        step(); chk("t2_idle", 1'b0, 4'b0000);

        // Origin path with dep_reg=1100.
        dep_vld = 4'b1100;
        for (int i = 0; i < THRESH - 1; i++) step();
        chk("t3_pre", 1'b0, 4'b0000);
        step(); chk("t3_detect", 1'b1, 4'b0000);
        dl_detect_in = 1'b1;
        step(); chk("t3_ack", 1'b0, 4'b0000);
        dep_vld = 4'b0000; origin = 1'b1;
        step(); chk("t3_origin", 1'b0, 4'b0100);
        origin = 1'b0;
        step(); chk("t3_origin_end", 1'b0, 4'b0000);

        // Token returns to origin: pulse only, then clear re-enables forwarding.
        token_in_vec = 4'b0100;
        step(); chk("t5_return", 1'b1, 4'b0000);
        token_in_vec = 4'b0000; token_clear = 1'b1;
        step(); chk("t5_clear", 1'b0, 4'b0000);
        token_clear = 1'b0; token_in_vec = 4'b1000;
        step(); chk("t5_after_clear", 1'b1, 4'b0100);
        token_in_vec = 4'b0000;
        step(); chk("t5_quiet", 1'b0, 4'b0000);

        // Origin and token together, then clear beating origin.
        origin = 1'b1; token_in_vec = 4'b0001;
        step(); chk("t3_orig_tok", 1'b1, 4'b0100);
        origin = 1'b0; token_in_vec = 4'b0000;
        step(); chk("t3_orig_tok_end", 1'b0, 4'b0000);
        token_in_vec = 4'b1000;
        step(); chk("t3_flag_set", 1'b1, 4'b0000);
        token_in_vec = 4'b0000; token_clear = 1'b1; origin = 1'b1;
        step(); chk("t3_clear_origin", 1'b0, 4'b0000);
        token_clear = 1'b0; origin = 1'b0; token_in_vec = 4'b1000;
        step(); chk("t3_flag_clear", 1'b1, 4'b0100);
        token_in_vec = 4'b0010;
        step(); chk("t3_own_tok", 1'b0, 4'b0000);
        token_in_vec = 4'b0000;

        // Leaving ARMED clears the counter: full threshold needed again.
        dl_detect_in = 1'b0;
        step(); chk("t6_exit", 1'b0, 4'b0000);
        dep_vld = 4'b1000;
        for (int i = 0; i < THRESH - 1; i++) begin
            step();
            chk("t6_recount", 1'b0, 4'b0000);
        end
        step(); chk("t6_redetect", 1'b1, 4'b0000);
        dep_vld = 4'b0000;
        step(); chk("t6_idle", 1'b0, 4'b0000);

        // Forward hop after arming directly from IDLE, dep_reg=0001.
        dep_vld = 4'b0001; dl_detect_in = 1'b1;
        step(); chk("t4_direct_arm", 1'b0, 4'b0000);
        dep_vld = 4'b0000; token_in_vec = 4'b1000;
        step(); chk("t4_hop", 1'b1, 4'b0001);
        token_in_vec = 4'b0000;
        step(); chk("t4_hop_end", 1'b0, 4'b0000);

        // Asynchronous reset with a token pulse in flight.
        token_in_vec = 4'b1000;
        step(); chk("t6_pending", 1'b1, 4'b0001);
        token_in_vec = 4'b0000;
        #2 reset = 1'b1;
        #1 chk("t6_async_reset", 1'b0, 4'b0000);
        dl_detect_in = 1'b0;
        step(); chk("t6_reset_hold", 1'b0, 4'b0000);
        reset = 1'b0;
        step(); chk("t6_after_reset", 1'b0, 4'b0000);

        // Armed with no dependences: origin produces no token.
        dl_detect_in = 1'b1;
        step(); chk("t7_arm_empty", 1'b0, 4'b0000);
        origin = 1'b1;
        step(); chk("t7_no_dep", 1'b0, 4'b0000);
        origin = 1'b0; token_in_vec = 4'b1000;
        step(); chk("t7_tok_no_dep", 1'b1, 4'b0000);
        token_in_vec = 4'b0000; dl_detect_in = 1'b0;
        step(); chk("t7_exit", 1'b0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/deadlock_detect_unit.md
Name: deadlock_detect_unit

Overview:
- Per-process deadlock detector; one instance per dataflow process (PROC_ID) in the cosim testbench.
- Drives one bit of the deadlock report unit's dl_in_vec. Watches this process's blocking status on channels to its peer processes.
- After detection, acts as a node in a token ring. It forwards the report unit's origin token along its recorded dependences so the report unit can trace each dependence cycle.

Parameters:
- PROC_NUM, 4, number of processes in the dataflow region (width of all vectors).
- PROC_ID, 0, index of this process; its own bit is masked in every vector.
- BLOCK_THRESHOLD, 16, consecutive blocked cycles required to declare self-deadlock (minimum 1).
- CNT_W, $clog2(BLOCK_THRESHOLD+1), blocked-cycle counter width.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- dep_vld  in  PROC_NUM  bit j=1: this process is currently stalled on a channel or start-FIFO toward process j.
- token_in_vec  in  PROC_NUM  bit j=1 for one cycle: process j forwards the token to this process.
- dl_detect_in  in  1  global "deadlock confirmed" level from the report unit.
- origin  in  1  this process's bit of the report unit's origin vector (one-cycle pulse).
- token_clear  in  1  report unit's end-of-cycle pulse.
- dl_detect_out  out  1  this process's bit of dl_in_vec.
- token_out_vec  out  PROC_NUM  one-hot, one-cycle: token forwarded to process j.

Behaviour:
- Reset values:
  - state=ST_IDLE; cnt=0; dep_reg=0; origin_flag=0.
  - dl_detect_out=0; token_out_vec=0. Both outputs are registered.
- Masking: dep_m = dep_vld & ~(1<<PROC_ID). blocked = |dep_m.
- Blocked counter:
  - In ST_IDLE, cnt increments each cycle blocked=1 and saturates at BLOCK_THRESHOLD.
  - Any cycle with blocked=0 sets cnt=0.
- ST_IDLE:
  - If dl_detect_in=1, go to ST_ARMED and set dep_reg<=dep_m. This handles procs that are part of a cycle but never reached the threshold.
  - Else, if blocked and cnt==BLOCK_THRESHOLD-1, go to ST_DETECTED and set dep_reg<=dep_m.
- ST_DETECTED:
  - dl_detect_out=1 (level) for the whole state.
  - If dl_detect_in=1, go to ST_ARMED and drop dl_detect_out to 0 on entry. This is exactly one cycle after the report unit captures the vector, so the level never overlaps its report phase.
  - Else, if blocked=0 (false alarm), go to ST_IDLE with cnt=0 and dep_reg=0.
- ST_ARMED:
  - dep_reg is frozen.
  - tgt = lowest set bit of dep_reg, one-hot; tgt=0 if dep_reg==0.
  - origin=1 at cycle t: origin_flag<=1, and token_out_vec=tgt during t+1 only.
  - |token_in_vec=1 at cycle t:
    - dl_detect_out=1 during t+1 only (one-hop latency 1 cycle).
    - If origin_flag=0, token_out_vec=tgt during t+1.
    - If origin_flag=1 (token returned to origin), no forward.
  - token_clear=1: origin_flag<=0. This takes priority over simultaneous origin; any simultaneous token_in is still pulsed on dl_detect_out.
  - origin and token_in in the same cycle: the origin forward wins; a single tgt pulse is issued and origin_flag is set.
  - dl_detect_in falls to 0: return to ST_IDLE and clear dep_reg, origin_flag, cnt and both outputs.
- Reset asserted mid-operation: immediate return to reset values, independent of clock. Any in-flight token pulse is dropped.
- Invariant: token_out_vec is at most one-hot and never has bit PROC_ID set.

Decomposition:
- Shared package deadlock_pkg:
  - State encodings ST_IDLE/ST_DETECTED/ST_ARMED (2 bits).
  - Function lowest_onehot(vec).
  - Function proc_mask(id).
  - Also used by the report unit.
- One sub-module: dl_block_timer (saturating blocked-cycle counter with clear; outputs hit pulse).

Test Plan (PROC_NUM=4, PROC_ID=1, BLOCK_THRESHOLD=8):
1. Detection: dep_vld=4'b0100 held from cycle 0 -> dl_detect_out rises after cycle 8 edge (state ST_DETECTED), dep_reg=4'b0100. dep_vld=4'b0110 never sets bit 1 path (mask).
2. False alarm: dep_vld=4'b1000 for 5 cycles, then 0 -> dl_detect_out stays 0, cnt returns to 0. Detect at 8 cycles, then dep_vld=0 before dl_detect_in -> back to ST_IDLE, output 0 next cycle.
3. Origin path: ST_DETECTED, dep_reg=4'b1100; dl_detect_in=1 -> dl_detect_out=0 next cycle. Then origin pulse at t -> token_out_vec=4'b0100 at t+1 only.
4. Forward hop: ST_ARMED, origin_flag=0, dep_reg=4'b0001; token_in_vec=4'b1000 at t -> dl_detect_out=1 and token_out_vec=4'b0001 at t+1, both 0 at t+2.
5. Return to origin: origin_flag=1; token_in_vec=4'b0100 at t -> dl_detect_out pulse at t+1, token_out_vec=0. token_clear at t+1 -> origin_flag=0.
6. Reset/exit: assert reset during ST_ARMED with pending token -> all outputs 0 immediately. Separately, dropping dl_detect_in -> ST_IDLE, cnt=0.
